// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_BE_W   = WB_DATA_W / 8;

    // One register-file write: destination, data, active-low byte enables.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_BE_W-1:0]   be_n;
    } wb_req_t;

    // Byte-enable pattern meaning "write nothing".
    localparam logic [WB_BE_W-1:0] BE_NONE = '1;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    // Register 0 is hard-wired and an all-ones enable writes no byte, so
    // either makes the request a null write that never occupies the port.
    function automatic logic is_real(input wb_req_t r);
        return (r.addr != '0) && (r.be_n != BE_NONE);
    endfunction

endpackage

// File: rtl/wb_sec_fifo.sv
// Small synchronous FIFO holding buffered secondary writebacks.
// Exposes per-entry address taps and valid flags for hazard compares.
module wb_sec_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_i,
    input  logic                              pop_i,
    input  wb_req_t                           din_i,
    output wb_req_t                           dout_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]   tap_addr_o,
    output logic [DEPTH-1:0]                  tap_valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   off;

    // Pointer and occupancy update; reset drops every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        off         = '0;
        tap_valid_o = '0;
        tap_addr_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr_q;
            tap_valid_o[i] = ({1'b0, off} < count_q);
            tap_addr_o[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback (primary) and a buffered multi-cycle unit (secondary).
// Optional macro WB_ARB_HAZARD_EN enables the rs/rt pending-write compare.
//
// state  | meaning
// NORMAL | primary wins the port, buffered head drains in idle slots
// FORCE  | one-cycle pipeline stall, buffered head takes the port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    // The request struct is sized by the package; keep these equal to it.
    parameter int DATA_WIDTH   = WB_DATA_W,
    parameter int ADDR_WIDTH   = WB_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pri_valid,
    input  logic [ADDR_WIDTH-1:0]   pri_addr,
    input  logic [DATA_WIDTH-1:0]   pri_data,
    input  logic [DATA_WIDTH/8-1:0] pri_be_n,
    input  logic                    sec_valid,
    output logic                    sec_ready,
    input  logic [ADDR_WIDTH-1:0]   sec_addr,
    input  logic [DATA_WIDTH-1:0]   sec_data,
    input  logic [DATA_WIDTH/8-1:0] sec_be_n,
    output logic                    stall,
    output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
    output logic [DATA_WIDTH-1:0]   rf_rd_in,
    output logic [DATA_WIDTH/8-1:0] rf_byte_w_en,
    input  logic [ADDR_WIDTH-1:0]   rs_addr,
    input  logic [ADDR_WIDTH-1:0]   rt_addr,
    output logic                    rs_hazard,
    output logic                    rt_hazard
);

    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    wb_req_t     rf_q;

    wb_req_t     pri_req;
    wb_req_t     sec_req;
    wb_req_t     head_req;
    wb_req_t     issue_req;
    logic        issue;
    logic        pri_real;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0]                       fifo_count;
    logic [FIFO_DEPTH-1:0][WB_ADDR_W-1:0] tap_addr;
    logic [FIFO_DEPTH-1:0]               tap_valid;

    assign pri_req  = '{addr: pri_addr, data: pri_data, be_n: pri_be_n};
    assign sec_req  = '{addr: sec_addr, data: sec_data, be_n: sec_be_n};
    assign pri_real = pri_valid && is_real(pri_req);

    // Null secondary writes are accepted but never buffered, so every
    // FIFO entry is a real write.
    assign sec_ready = !fifo_full && !rst;
    assign push      = sec_valid && sec_ready && is_real(sec_req);

    wb_sec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       (sec_req),
        .dout_o      (head_req),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .tap_addr_o  (tap_addr),
        .tap_valid_o (tap_valid)
    );

    // Port grant, starvation tracking and next state.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        pop       = 1'b0;
        stall     = 1'b0;
        issue     = 1'b0;
        issue_req = pri_req;
        case (state_q)
            NORMAL: begin
                if (pri_real) begin
                    issue = 1'b1;
                    if (fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                        state_d  = FORCE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (!fifo_empty) begin
                    issue     = 1'b1;
                    issue_req = head_req;
                    pop       = 1'b1;
                    starve_d  = '0;
                end else begin
                    starve_d = '0;
                end
            end
            FORCE: begin
                stall    = 1'b1;
                starve_d = '0;
                state_d  = NORMAL;
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    issue_req = head_req;
                    pop       = 1'b1;
                end
            end
            default: begin
                state_d  = NORMAL;
                starve_d = '0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Registered register-file write port; idle cycles present a no-write.
    // Data is held on idle cycles since the enables already block the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q.addr <= '0;
            rf_q.data <= '0;
            rf_q.be_n <= BE_NONE;
        end else if (issue) begin
            rf_q <= issue_req;
        end else begin
            rf_q.addr <= '0;
            rf_q.be_n <= BE_NONE;
        end
    end

    assign rf_rd_addr   = rf_q.addr;
    assign rf_rd_in     = rf_q.data;
    assign rf_byte_w_en = rf_q.be_n;

`ifdef WB_ARB_HAZARD_EN
    logic rs_hit;
    logic rt_hit;
    logic rf_live;

    assign rf_live = (rf_q.be_n != BE_NONE);

    // Source index hits a buffered write or the write being committed now.
    always_comb begin
        rs_hit = rf_live && (rf_q.addr == rs_addr);
        rt_hit = rf_live && (rf_q.addr == rt_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (tap_valid[i] && (tap_addr[i] == rs_addr)) rs_hit = 1'b1;
            if (tap_valid[i] && (tap_addr[i] == rt_addr)) rt_hit = 1'b1;
        end
    end

    assign rs_hazard = rs_hit && (rs_addr != '0);
    assign rt_hazard = rt_hit && (rt_addr != '0);

    logic unused_bits;
    assign unused_bits = ^fifo_count;
`else
    assign rs_hazard = 1'b0;
    assign rt_hazard = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{fifo_count, tap_addr, tap_valid, rs_addr, rt_addr};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write-order scoreboard
// and a behavioural register file committing on negedge.
module tb_regfile_wb_arbiter;

`ifdef WB_ARB_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pri_valid;
    logic [4:0]  pri_addr;
    logic [31:0] pri_data;
    logic [3:0]  pri_be_n;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic [3:0]  sec_be_n;
    logic        stall;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_in;
    logic [3:0]  rf_byte_w_en;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_hazard;
    logic        rt_hazard;

    int total = 0;
    int bad   = 0;
    logic [40:0] exp_q [$];
    logic [40:0] sb_exp;
    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pri_valid    (pri_valid),
        .pri_addr     (pri_addr),
        .pri_data     (pri_data),
        .pri_be_n     (pri_be_n),
        .sec_valid    (sec_valid),
        .sec_ready    (sec_ready),
        .sec_addr     (sec_addr),
        .sec_data     (sec_data),
        .sec_be_n     (sec_be_n),
        .stall        (stall),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_in     (rf_rd_in),
        .rf_byte_w_en (rf_byte_w_en),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_hazard    (rs_hazard),
        .rt_hazard    (rt_hazard)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pri(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        pri_valid = 1'b1;
        pri_addr  = a;
        pri_data  = d;
        pri_be_n  = be;
    endtask

    task automatic drive_sec(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        sec_valid = 1'b1;
        sec_addr  = a;
        sec_data  = d;
        sec_be_n  = be;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back({a, d, be});
    endtask

    // Scoreboard and register-file model: every real write is checked in order.
    always @(negedge clk) begin
        if (rst === 1'b0 && rf_byte_w_en !== 4'hF) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_write", {59'b0, rf_rd_addr}, 64'h0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_write", {23'b0, rf_rd_addr, rf_rd_in, rf_byte_w_en}, {23'b0, sb_exp});
            end
            for (int b = 0; b < 4; b++) begin
                if (!rf_byte_w_en[b] && rf_rd_addr != 5'd0)
                    rf_model[rf_rd_addr][8*b +: 8] <= rf_rd_in[8*b +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;
        rst = 1'b1;
        pri_valid = 1'b0; pri_addr = '0; pri_data = '0; pri_be_n = 4'hF;
        sec_valid = 1'b0; sec_addr = '0; sec_data = '0; sec_be_n = 4'hF;
        rs_addr = '0; rt_addr = '0;
        tick();
        tick();
        chk("rst_sec_ready", {63'b0, sec_ready}, 64'd0);
        chk("rst_be", {60'b0, rf_byte_w_en}, 64'hF);
        rst = 1'b0;
        #1;
        chk("post_rst_sec_ready", {63'b0, sec_ready}, 64'd1);
        chk("post_rst_stall", {63'b0, stall}, 64'd0);
        chk("post_rst_addr", {59'b0, rf_rd_addr}, 64'd0);

        // Reset while two secondary entries are buffered.
        drive_pri(5'd1, 32'h1111_0001, 4'h0); push_exp(5'd1, 32'h1111_0001, 4'h0);
        drive_sec(5'd10, 32'h1010_1010, 4'h0);
        tick();
        chk("t1_ready_one", {63'b0, sec_ready}, 64'd1);
        drive_pri(5'd2, 32'h2222_0002, 4'h0); push_exp(5'd2, 32'h2222_0002, 4'h0);
        drive_sec(5'd11, 32'h1111_1111, 4'h0);
        tick();
        chk("t1_full_ready", {63'b0, sec_ready}, 64'd0);
        chk("t1_pri2_addr", {59'b0, rf_rd_addr}, 64'd2);
        @(negedge clk);
        #1;
        rst = 1'b1; pri_valid = 1'b0; sec_valid = 1'b0;
        tick();
        chk("t1_rst_ready", {63'b0, sec_ready}, 64'd0);
        chk("t1_rst_be", {60'b0, rf_byte_w_en}, 64'hF);
        rst = 1'b0;
        #1;
        chk("t1_ready_after", {63'b0, sec_ready}, 64'd1);
        chk("t1_stall_after", {63'b0, stall}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_idle_be", {60'b0, rf_byte_w_en}, 64'hF);
        end
        chk("t1_r10_unwritten", {32'b0, rf_model[10]}, 64'd0);
        chk("t1_r11_unwritten", {32'b0, rf_model[11]}, 64'd0);

        // Plain primary write and register-file commit.
        drive_pri(5'd5, 32'hDEAD_BEEF, 4'h0); push_exp(5'd5, 32'hDEAD_BEEF, 4'h0);
        tick();
        pri_valid = 1'b0;
        chk("t2_addr", {59'b0, rf_rd_addr}, 64'd5);
        chk("t2_data", {32'b0, rf_rd_in}, 64'hDEAD_BEEF);
        chk("t2_be", {60'b0, rf_byte_w_en}, 64'h0);
        @(negedge clk);
        #1;
        chk("t2_r5", {32'b0, rf_model[5]}, 64'hDEAD_BEEF);
        tick();

        // Starvation: four losses, then a forced drain with primary held.
        drive_sec(5'd7, 32'h0000_0777, 4'h0);
        for (int i = 0; i < 5; i++) begin
            drive_pri(5'(20 + i), 32'hA000_0000 + i, 4'h0);
            push_exp(5'(20 + i), 32'hA000_0000 + i, 4'h0);
            tick();
            sec_valid = 1'b0;
            chk("t3_pri_addr", {59'b0, rf_rd_addr}, 64'(20 + i));
            chk("t3_stall", {63'b0, stall}, (i == 4) ? 64'd1 : 64'd0);
        end
        drive_pri(5'd25, 32'hA000_0025, 4'h0);
        push_exp(5'd7, 32'h0000_0777, 4'h0);
        push_exp(5'd25, 32'hA000_0025, 4'h0);
        tick();
        chk("t3_force_addr", {59'b0, rf_rd_addr}, 64'd7);
        chk("t3_force_stall_off", {63'b0, stall}, 64'd0);
        tick();
        pri_valid = 1'b0;
        chk("t3_held_pri", {59'b0, rf_rd_addr}, 64'd25);
        tick();

        // Full FIFO back-pressure; third request waits for the first drain.
        drive_pri(5'd12, 32'hC000_0012, 4'h0); push_exp(5'd12, 32'hC000_0012, 4'h0);
        drive_sec(5'd13, 32'h5000_0013, 4'h0);
        tick();
        drive_pri(5'd14, 32'hC000_0014, 4'h0); push_exp(5'd14, 32'hC000_0014, 4'h0);
        drive_sec(5'd15, 32'h5000_0015, 4'h3);
        tick();
        chk("t4_full", {63'b0, sec_ready}, 64'd0);
        drive_pri(5'd16, 32'hC000_0016, 4'h0); push_exp(5'd16, 32'hC000_0016, 4'h0);
        drive_sec(5'd17, 32'h5000_0017, 4'h0);
        push_exp(5'd13, 32'h5000_0013, 4'h0);
        push_exp(5'd15, 32'h5000_0015, 4'h3);
        push_exp(5'd17, 32'h5000_0017, 4'h0);
        tick();
        chk("t4_still_full", {63'b0, sec_ready}, 64'd0);
        pri_valid = 1'b0;
        tick();
        chk("t4_drain1", {59'b0, rf_rd_addr}, 64'd13);
        chk("t4_ready_after_drain", {63'b0, sec_ready}, 64'd1);
        tick();
        sec_valid = 1'b0;
        chk("t4_drain2", {59'b0, rf_rd_addr}, 64'd15);
        chk("t4_ready_pushpop", {63'b0, sec_ready}, 64'd1);
        tick();
        chk("t4_drain3", {59'b0, rf_rd_addr}, 64'd17);
        tick();
        chk("t4_idle", {60'b0, rf_byte_w_en}, 64'hF);

        // Null primary (addr 0) lets the FIFO head through.
        drive_sec(5'd3, 32'h0303_0303, 4'h0);
        tick();
        sec_valid = 1'b0;
        drive_pri(5'd0, 32'hFFFF_FFFF, 4'h0);
        push_exp(5'd3, 32'h0303_0303, 4'h0);
        tick();
        pri_valid = 1'b0;
        chk("t5_head_addr", {59'b0, rf_rd_addr}, 64'd3);
        chk("t5_stall", {63'b0, stall}, 64'd0);
        drive_pri(5'd9, 32'h9999_9999, 4'hF);
        tick();
        pri_valid = 1'b0;
        chk("t5_null_be", {60'b0, rf_byte_w_en}, 64'hF);
        drive_sec(5'd0, 32'h0000_0005, 4'h0);
        tick();
        sec_valid = 1'b0;
        chk("t5_null_sec_ready", {63'b0, sec_ready}, 64'd1);
        tick();
        chk("t5_null_sec_be", {60'b0, rf_byte_w_en}, 64'hF);
        chk("t5_r0", {32'b0, rf_model[0]}, 64'd0);

        // Hazard outputs against a buffered write to register 9.
        rs_addr = 5'd9;
        rt_addr = 5'd0;
        drive_pri(5'd20, 32'h2020_2020, 4'h0); push_exp(5'd20, 32'h2020_2020, 4'h0);
        drive_sec(5'd9, 32'h0909_0909, 4'h0);  push_exp(5'd9, 32'h0909_0909, 4'h0);
        tick();
        sec_valid = 1'b0;
        pri_valid = 1'b0;
        chk("t6_rs_buffered", {63'b0, rs_hazard}, {63'b0, HZ});
        chk("t6_rt_zero", {63'b0, rt_hazard}, 64'd0);
        tick();
        chk("t6_drain_addr", {59'b0, rf_rd_addr}, 64'd9);
        chk("t6_rs_driven", {63'b0, rs_hazard}, {63'b0, HZ});
        tick();
        chk("t6_rs_clear", {63'b0, rs_hazard}, 64'd0);

        tick();
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
